// File: rtl/spio_pkg.sv
// Shared types and default sizing for the serial LED / 7-segment
// output arbiter.
package spio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } spio_state_e;

   localparam int SPIO_W_A     = 16;
   localparam int SPIO_W_B     = 64;
   localparam int SPIO_CLK_DIV = 2;

   function automatic int spio_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spio_p2s_core.sv
// Loadable MSB-first shift register with bit counter and s_clk divider.
// Frames are left-aligned in data; len gives the number of bits to send.
module spio_p2s_core #(
   parameter int W       = 64,
   parameter int CLK_DIV = 2,
   parameter int CW      = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] len,
   input  logic [W-1:0]  data,
   output logic          done,
   output logic          s_clk,
   output logic          s_dout
);

   localparam int DW = 9;
   localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);

   logic          active;
   logic [W-1:0]  sr;
   logic [CW-1:0] bits_left;
   logic [DW-1:0] div;

   assign done = active && (div == DIV_LAST)
              && (bits_left == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         active    <= 1'b0;
         sr        <= '0;
         bits_left <= '0;
         div       <= '0;
         s_clk     <= 1'b0;
         s_dout    <= 1'b0;
      end else if (load) begin
         active    <= 1'b1;
         sr        <= data;
         bits_left <= len;
         div       <= '0;
         s_clk     <= 1'b0;
         s_dout    <= data[W-1];
      end else if (active) begin
         if (div == DIV_LAST) begin
            div   <= '0;
            s_clk <= 1'b0;
            if (bits_left == CW'(1)) begin
               active <= 1'b0;
               s_dout <= 1'b0;
            end else begin
               sr        <= sr << 1;
               s_dout    <= sr[W-2];
               bits_left <= bits_left - CW'(1);
            end
         end else begin
            div   <= div + DW'(1);
            // s_clk rises once the low half of the bit has elapsed
            s_clk <= ((div + DW'(1)) >= DIV_HALF);
         end
      end
   end

endmodule

// File: rtl/spio_serial_arb.sv
// Round-robin arbiter sharing one serial shift chain between the LED
// bank (A) and the 7-segment display (B).
module spio_serial_arb
   import spio_pkg::*;
#(
   parameter int W_A     = SPIO_W_A,
   parameter int W_B     = SPIO_W_B,
   parameter int CLK_DIV = SPIO_CLK_DIV
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_a,
   input  logic [W_A-1:0] data_a,
   input  logic           req_b,
   input  logic [W_B-1:0] data_b,
   output logic           ack_a,
   output logic           ack_b,
   output logic           busy,
   output logic           s_clk,
   output logic           s_dout,
   output logic           s_clrn,
   output logic           s_pen_a,
   output logic           s_pen_b
);

   localparam int WM = spio_max(W_A, W_B);
   localparam int CW = $clog2(WM + 1);
   localparam int LW = 9;
   localparam logic [LW-1:0] LAT_LAST = LW'(2 * CLK_DIV - 1);

   spio_state_e   state, state_n;
   logic          last_b, sel_b, pick_b;
   logic          load, done;
   logic          ack_a_n, ack_b_n, pen_a_n, pen_b_n;
   logic [LW-1:0] lat_cnt;
   logic [WM-1:0] frame_a, frame_b, frame;
   logic [CW-1:0] len;

   always_comb begin
      frame_a = '0;
      frame_b = '0;
      frame_a[WM-1 -: W_A] = data_a;
      frame_b[WM-1 -: W_B] = data_b;
   end

   // on a tie, B wins only if A was granted most recently
   assign pick_b = req_b & (~req_a | ~last_b);
   assign frame  = pick_b ? frame_b : frame_a;
   assign len    = pick_b ? CW'(W_B) : CW'(W_A);

   always_comb begin
      state_n = state;
      load    = 1'b0;
      ack_a_n = 1'b0;
      ack_b_n = 1'b0;
      pen_a_n = 1'b0;
      pen_b_n = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req_a | req_b) begin
               load    = 1'b1;
               state_n = ST_SHIFT;
               ack_a_n = ~pick_b;
               ack_b_n = pick_b;
            end
         end
         ST_SHIFT: begin
            if (done) begin
               state_n = ST_LATCH;
               pen_a_n = ~sel_b;
               pen_b_n = sel_b;
            end
         end
         ST_LATCH: begin
            if (lat_cnt == LAT_LAST) begin
               state_n = ST_IDLE;
            end else begin
               pen_a_n = ~sel_b;
               pen_b_n = sel_b;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ack_a   <= 1'b0;
         ack_b   <= 1'b0;
         s_pen_a <= 1'b0;
         s_pen_b <= 1'b0;
         busy    <= 1'b0;
         s_clrn  <= 1'b0;
         last_b  <= 1'b1;
         sel_b   <= 1'b0;
         lat_cnt <= '0;
      end else begin
         state   <= state_n;
         ack_a   <= ack_a_n;
         ack_b   <= ack_b_n;
         s_pen_a <= pen_a_n;
         s_pen_b <= pen_b_n;
         busy    <= (state_n != ST_IDLE);
         s_clrn  <= 1'b1;
         if (load) begin
            last_b <= pick_b;
            sel_b  <= pick_b;
         end
         if (state == ST_LATCH)
            lat_cnt <= lat_cnt + LW'(1);
         else
            lat_cnt <= '0;
      end
   end

   spio_p2s_core #(
      .W       (WM),
      .CLK_DIV (CLK_DIV),
      .CW      (CW)
   ) u_p2s (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .len    (len),
      .data   (frame),
      .done   (done),
      .s_clk  (s_clk),
      .s_dout (s_dout)
   );

endmodule

// File: tb/tb_spio_serial_arb.sv
// Directed bench for spio_serial_arb with CLK_DIV=2, W_A=16, W_B=64.
module tb_spio_serial_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_a, req_b;
   logic [15:0] data_a;
   logic [63:0] data_b;
   logic        ack_a, ack_b, busy;
   logic        s_clk, s_dout, s_clrn;
   logic        s_pen_a, s_pen_b;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   spio_serial_arb #(
      .W_A     (16),
      .W_B     (64),
      .CLK_DIV (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_a   (req_a),
      .data_a  (data_a),
      .req_b   (req_b),
      .data_b  (data_b),
      .ack_a   (ack_a),
      .ack_b   (ack_b),
      .busy    (busy),
      .s_clk   (s_clk),
      .s_dout  (s_dout),
      .s_clrn  (s_clrn),
      .s_pen_a (s_pen_a),
      .s_pen_b (s_pen_b)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {busy, ack_a, ack_b, s_clk,
              s_dout, s_pen_a, s_pen_b, s_clrn};
   endfunction

   task automatic wait_ack(output logic ga, output logic gb);
      ga = 1'b0;
      gb = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack_a | ack_b) begin
            ga = ack_a;
            gb = ack_b;
            return;
         end
      end
      chk("ack_timeout", 64'd0, 64'd1);
   endtask

   // entered at the negedge of the ack cycle; leaves in the IDLE cycle
   task automatic collect(input logic is_b,
                          input logic [63:0] exp,
                          input int nbits,
                          input string tag);
      int sh, edges, acks, pens, side;
      logic [63:0] st;
      logic prev;
      sh = 0; edges = 0; acks = 0;
      st = '0; prev = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (s_pen_a | s_pen_b) break;
         if (busy) sh++;
         if (is_b ? ack_b : ack_a) acks++;
         if (s_clk && !prev) begin
            st = {st[62:0], s_dout};
            edges++;
         end
         prev = s_clk;
         @(negedge clk);
      end
      chk({tag, "_edges"}, 64'(edges), 64'(nbits));
      chk({tag, "_shift"}, 64'(sh), 64'(nbits * 4));
      chk({tag, "_stream"}, st, exp);
      chk({tag, "_acks"}, 64'(acks), 64'd1);
      pens = 0; side = 0;
      for (int i = 0; i < 50; i++) begin
         if (!(is_b ? s_pen_b : s_pen_a)) break;
         pens++;
         if ((is_b ? s_pen_a : s_pen_b) | s_clk
             | s_dout | !busy)
            side++;
         @(negedge clk);
      end
      chk({tag, "_pen"}, 64'(pens), 64'd4);
      chk({tag, "_latch"}, 64'(side), 64'd0);
      chk({tag, "_idle"}, 64'(outs()), 64'h01);
   endtask

   logic        ga, gb;
   logic [15:0] tie_a;
   logic [63:0] tie_b;
   int          stray;

   initial begin
      rst = 1'b1;
      req_a = 1'b0; req_b = 1'b0;
      data_a = '0; data_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_outs", 64'(outs()), 64'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel", 64'(outs()), 64'h01);

      // single A
      data_a = 16'h8001; req_a = 1'b1;
      wait_ack(ga, gb);
      chk("a_grant", {ga, gb}, 2'b10);
      req_a = 1'b0;
      collect(1'b0, 64'h8001, 16, "a");

      // single B
      data_b = 64'hFFFF_0000_AAAA_5555; req_b = 1'b1;
      wait_ack(ga, gb);
      chk("b_grant", {ga, gb}, 2'b01);
      req_b = 1'b0;
      collect(1'b1, 64'hFFFF_0000_AAAA_5555, 64, "b");

      // reset mid-SHIFT aborts with no strobe
      data_a = 16'hFFFF; req_a = 1'b1;
      wait_ack(ga, gb);
      req_a = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst", 64'(outs()), 64'h00);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rel", 64'(outs()), 64'h01);
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_pen_a | s_pen_b | ack_a | ack_b | busy)
            stray++;
      end
      chk("mid_quiet", 64'(stray), 64'd0);

      // tie: A first after reset, then alternate
      tie_a = 16'h1234;
      tie_b = 64'h0123_4567_89AB_CDEF;
      data_a = tie_a; data_b = tie_b;
      req_a = 1'b1; req_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin
            wait_ack(ga, gb);
         end else begin
            @(negedge clk);
            ga = ack_a;
            gb = ack_b;
         end
         chk($sformatf("tie%0d_grant", k), {ga, gb},
             (k % 2 == 0) ? 2'b10 : 2'b01);
         if (k == 3) begin
            req_a = 1'b0; req_b = 1'b0;
         end
         if (k % 2 == 0)
            collect(1'b0, 64'(tie_a), 16,
                    $sformatf("tie%0d", k));
         else
            collect(1'b1, tie_b, 64,
                    $sformatf("tie%0d", k));
      end

      // captured frame survives data/req changes
      data_a = 16'hC3A5; req_a = 1'b1;
      wait_ack(ga, gb);
      chk("iso_grant", {ga, gb}, 2'b10);
      data_a = 16'h0F0F; req_a = 1'b0;
      collect(1'b0, 64'hC3A5, 16, "iso");
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ack_a | ack_b | busy) stray++;
      end
      chk("iso_quiet", 64'(stray), 64'd0);

      $display("test done: total=%0d bad=%0d",
               n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/spio_serial_arb.md
SPIO_SERIAL_ARB -- requirements
Module: spio_serial_arb

Interface
REQ-001 SHALL have parameter W_A, default 16, bit width of requester A (LED bank) frame.
REQ-002 SHALL have parameter W_B, default 64, bit width of requester B (7-segment) frame.
REQ-003 SHALL have parameter CLK_DIV, default 2, clk cycles per s_clk half-period, legal range 1..255.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports req_a, input, 1, and data_a, input, W_A: request from A and its frame.
REQ-007 SHALL have ports req_b, input, 1, and data_b, input, W_B: request from B and its frame.
REQ-008 SHALL have ports ack_a and ack_b, output, 1 each: one-cycle pulse when that requester's frame is captured.
REQ-009 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-010 SHALL have ports s_clk, output, 1, and s_dout, output, 1: shared shift clock and serial data.
REQ-011 SHALL have port s_clrn, output, 1: active-low clear for both external shift chains.
REQ-012 SHALL have ports s_pen_a and s_pen_b, output, 1 each: latch strobe for chain A and chain B.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, LATCH; transitions: IDLE->SHIFT on grant, SHIFT->LATCH after last bit, LATCH->IDLE after 2*CLK_DIV cycles.
REQ-014 SHALL evaluate requests only in IDLE; if exactly one req is high, grant it.
REQ-015 SHALL resolve simultaneous req_a and req_b round-robin: grant the requester not granted most recently.
REQ-016 SHALL, on grant at edge t, capture the frame, assert the matching ack during cycle t+1 only, and enter SHIFT in cycle t+1.
REQ-017 SHALL shift the captured frame MSB first, one bit per 2*CLK_DIV cycles.
REQ-018 SHALL hold s_clk low for the first CLK_DIV cycles of each bit and high for the next CLK_DIV cycles, with s_dout stable across the whole bit.
REQ-019 SHALL send exactly W_A bits for A and W_B bits for B; the bit counter is sized for max(W_A,W_B).
REQ-020 SHALL, in LATCH, hold s_clk low, s_dout low, and drive the granted chain's s_pen high for 2*CLK_DIV cycles; the other s_pen stays low.
REQ-021 SHALL ignore changes to req_x and data_x after capture; the transaction completes with captured data.
REQ-022 SHALL treat req held high through ack as a new request at the next IDLE; one-shot requesters drop req on ack.
REQ-023 SHALL spend exactly one cycle in IDLE between transactions when requests are pending.
REQ-024 SHALL, in IDLE, drive s_clk, s_dout, s_pen_a and s_pen_b low and both acks low.
REQ-025 SHALL make all outputs registered, with no combinational path from req or data to outputs.

Reset
REQ-026 SHALL, while rst is high, force IDLE, busy=0, acks=0, s_clk=0, s_dout=0, s_pen_a=0, s_pen_b=0, s_clrn=0.
REQ-027 SHALL drive s_clrn high from the first cycle after rst deasserts.
REQ-028 SHALL set the round-robin pointer on reset to "last granted = B", so A wins the first tie.
REQ-029 SHALL abort an in-flight SHIFT or LATCH on reset with no strobe and no ack; the frame is lost.

Structure
REQ-030 SHALL take the FSM state enum and default values for W_A, W_B and CLK_DIV from shared package spio_pkg.
REQ-031 SHALL instantiate one sub-module, spio_p2s_core: a loadable shift register with bit counter and s_clk divider, reporting done to the arbiter FSM.

Verification (CLK_DIV=2, W_A=16, W_B=64)
REQ-032 Reset: rst held 3 cycles mid-SHIFT -> all outputs 0, s_clrn=0, no s_pen pulse; s_clrn=1 one cycle after release.
REQ-033 Single A: req_a=1 with data_a=16'h8001 in IDLE -> ack_a one cycle; s_dout=1 for bit 0, 0 for bits 1..14, 1 for bit 15; 16 s_clk rising edges; 64 SHIFT cycles; then s_pen_a high 4 cycles, busy low after.
REQ-034 Single B: data_b=64'hFFFF_0000_AAAA_5555 -> 64 s_clk rising edges, serial stream equals data_b MSB first; s_pen_b high 4 cycles; s_pen_a stays 0.
REQ-035 Tie after reset: req_a and req_b both held high -> grants A, B, A, B in order; ack_a and ack_b alternate; exactly one IDLE cycle between transactions.
REQ-036 Capture isolation: data_a changed and req_a dropped the cycle after ack_a -> serial stream equals the original data_a; no second transaction.
